priority_resolver_isr: RTL
==========================

Name: priority_resolver_isr

Overview:
- Sits directly downstream of the interrupt request register (IRR) in the 8259A PIC.
- Masks and resolves IRR bits under fully-nested rotating priority, raises INT, and runs the two-pulse INTA acknowledge sequence.
- Maintains the in-service register (ISR) and handles EOI, automatic EOI and priority rotation.
- Drives clear_ir_line and freeze back into the IRR.

Parameters:
- NUM_IR, 8, number of interrupt lines (fixed at 8; vector fields are 3 bits).
- RESET_LOWEST, 7, level that holds lowest priority after reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- interrupt_req_reg  input  8  IRR contents.
- interrupt_mask  input  8  IMR; 1 = line masked.
- inta_n  input  1  CPU acknowledge, active-low, synchronous to clk.
- auto_eoi  input  1  1 = clear ISR at end of second INTA.
- rotate_on_aeoi  input  1  rotate priority on automatic EOI.
- eoi_cmd  input  1  one-cycle EOI command strobe.
- eoi_specific  input  1  1 = specific EOI using eoi_level.
- eoi_rotate  input  1  rotate priority on this EOI.
- eoi_level  input  3  level for specific EOI.
- set_priority  input  1  one-cycle strobe; set_level becomes lowest priority.
- set_level  input  3  level for set_priority.
- int_out  output  1  interrupt request to CPU.
- clear_ir_line  output  8  one-hot, one-cycle clear to IRR.
- freeze  output  1  holds IRR during acknowledge.
- in_service_reg  output  8  ISR.
- vector_level  output  3  acknowledged level (7 if spurious).
- vector_en  output  1  vector drive window (second INTA low).
- lowest_priority  output  3  current lowest-priority level.

Behaviour:
- Reset, asynchronous on reset=0: int_out=0, clear_ir_line=0, freeze=0, in_service_reg=0, vector_level=0, vector_en=0, lowest_priority=RESET_LOWEST, FSM=IDLE, stored inta_n=1.
- Priority: the level lowest_priority+1 (mod 8) is highest, descending cyclically through lowest_priority.
- pending = interrupt_req_reg & ~interrupt_mask.
- Eligible: a pending level strictly higher in priority than the highest-priority set ISR bit. All pending levels are eligible when the ISR is empty.
- Winner: the highest-priority eligible level. The search is combinational.
- int_out: registered. Equals (any eligible) in IDLE. Forced 0 in every other state.
- INTA edges: detected from a registered copy of inta_n. A falling edge is prev=1, now=0.
- FSM states:
  - IDLE: on INTA falling edge -> ACK1, and in the same clock:
    - freeze<=1.
    - If an eligible level exists: ISR[winner]<=1, clear_ir_line<=onehot(winner) for exactly 1 cycle, vector_level<=winner.
    - Otherwise (spurious): vector_level<=7, no ISR or clear change, spurious flag set.
  - ACK1: INTA rising edge -> WAIT2.
  - WAIT2: INTA falling edge -> ACK2, vector_en<=1.
  - ACK2: INTA rising edge -> IDLE, with vector_en<=0 and freeze<=0. If auto_eoi=1 and not spurious: ISR[vector_level]<=0. If rotate_on_aeoi is also 1: lowest_priority<=vector_level.
- EOI (eoi_cmd=1, accepted in any state):
  - Non-specific: clears the highest-priority set ISR bit.
  - Specific: clears ISR[eoi_level].
  - If eoi_rotate=1 and a bit was cleared: lowest_priority<=cleared level.
  - EOI with an empty ISR, or a specific EOI to a clear bit: no change.
- set_priority: lowest_priority<=set_level. If eoi_cmd with eoi_rotate fires in the same cycle, the EOI rotation wins.
- Simultaneous ISR set and EOI clear in one cycle: both apply to their respective bits. If they target the same bit, the set wins.
- Reset mid-sequence: returns to IDLE immediately. freeze and vector_en drop asynchronously.
- IRR bit changes after the first INTA do not affect the latched vector_level.

Test Plan:
- IRR=0x24, IMR=0, reset priority -> int_out=1. First INTA sets ISR=0x04, one-cycle clear_ir_line=0x04, freeze=1. Second INTA gives vector_en=1 with vector_level=2. After its rising edge freeze=0.
- ISR=0x04; IRR=0x08 -> int_out stays 0. IRR=0x01 -> int_out=1 (nesting). Non-specific EOI then clears bit 0 first.
- auto_eoi=1, rotate_on_aeoi=1, IRR=0x10 -> after second INTA rising edge ISR=0x00 and lowest_priority=4. Next IRR=0x30 -> winner 5.
- IRR=0x01 is withdrawn after int_out rises, before first INTA -> spurious: vector_level=7, ISR unchanged, clear_ir_line stays 0.
- Specific EOI level 3 with eoi_rotate=1 in the same cycle as set_priority level 6 -> ISR bit 3 cleared, lowest_priority=3.
- reset=0 asserted in WAIT2 -> all outputs at reset values within that cycle. After release, IRR=0x80 is handled normally.

Source files
------------

// File: rtl/priority_resolver_isr.sv
// Priority resolver and in-service register for an 8259A-style PIC.
// Masks the IRR, picks the highest-priority eligible level under rotating
// fully-nested priority, raises int_out, and runs the two-pulse INTA
// acknowledge sequence. Also owns the ISR, EOI/AEOI handling and rotation.
//
// Handshake: inta_n is a level from the CPU, already synchronous to clk.
// Edges are found by comparing it with its registered copy. A falling edge in
// IDLE latches the winner; the second falling edge opens the vector window;
// the rising edge that ends the second pulse closes the sequence.
module priority_resolver_isr #(
   parameter int          NUM_IR       = 8,
   parameter logic [2:0]  RESET_LOWEST = 3'd7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_IR-1:0] interrupt_req_reg,
   input  logic [NUM_IR-1:0] interrupt_mask,
   input  logic              inta_n,
   input  logic              auto_eoi,
   input  logic              rotate_on_aeoi,
   input  logic              eoi_cmd,
   input  logic              eoi_specific,
   input  logic              eoi_rotate,
   input  logic [2:0]        eoi_level,
   input  logic              set_priority,
   input  logic [2:0]        set_level,
   output logic              int_out,
   output logic [NUM_IR-1:0] clear_ir_line,
   output logic              freeze,
   output logic [NUM_IR-1:0] in_service_reg,
   output logic [2:0]        vector_level,
   output logic              vector_en,
   output logic [2:0]        lowest_priority,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACK1  = 2'd1,
      S_WAIT2 = 2'd2,
      S_ACK2  = 2'd3
   } state_t;

   localparam logic [NUM_IR-1:0] ONE = {{(NUM_IR-1){1'b0}}, 1'b1};

   state_t            state, state_next;
   logic              inta_q;
   logic              spurious, spurious_next;
   logic              int_next, freeze_next, vector_en_next;
   logic [2:0]        vector_level_next, lowest_next;
   logic [NUM_IR-1:0] clear_next, isr_next;

   logic [NUM_IR-1:0] pending;
   logic [NUM_IR-1:0] pend_rot, isr_rot;
   logic              pend_found, isr_found;
   logic [2:0]        pend_rank, isr_rank;
   logic              any_eligible;
   logic [2:0]        winner, isr_top_level;
   logic              inta_fall, inta_rise;

   logic [NUM_IR-1:0] isr_set, aeoi_clr, eoi_clr;
   logic              aeoi_rot;
   logic              eoi_hit;
   logic [2:0]        eoi_target;

   assign state_dbg = state;
   assign inta_fall = inta_q & ~inta_n;
   assign inta_rise = ~inta_q & inta_n;

   // Rotate pending and ISR so that bit 0 is the current highest priority,
   // then find the first set bit of each (rank 0 = highest priority).
   always_comb begin
      pending    = interrupt_req_reg & ~interrupt_mask;
      pend_rot   = '0;
      isr_rot    = '0;
      pend_found = 1'b0;
      isr_found  = 1'b0;
      pend_rank  = 3'd0;
      isr_rank   = 3'd0;
      for (int r = 0; r < NUM_IR; r++) begin
         pend_rot[r] = pending[3'(lowest_priority + 3'd1 + 3'(r))];
         isr_rot[r]  = in_service_reg[3'(lowest_priority + 3'd1 + 3'(r))];
      end
      for (int r = NUM_IR - 1; r >= 0; r--) begin
         if (pend_rot[r]) begin
            pend_found = 1'b1;
            pend_rank  = 3'(r);
         end
         if (isr_rot[r]) begin
            isr_found = 1'b1;
            isr_rank  = 3'(r);
         end
      end
      // Only the top pending level matters: if it is not above the top
      // in-service level, no lower-ranked pending level can be either.
      any_eligible  = pend_found && (!isr_found || (pend_rank < isr_rank));
      winner        = 3'(lowest_priority + 3'd1 + pend_rank);
      isr_top_level = 3'(lowest_priority + 3'd1 + isr_rank);
   end

   // Acknowledge sequencing, EOI handling and next values of all registers.
   always_comb begin
      state_next        = state;
      freeze_next       = freeze;
      vector_en_next    = vector_en;
      vector_level_next = vector_level;
      spurious_next     = spurious;
      clear_next        = '0;
      isr_set           = '0;
      aeoi_clr          = '0;
      aeoi_rot          = 1'b0;
      eoi_clr           = '0;
      eoi_hit           = 1'b0;
      eoi_target        = isr_top_level;

      case (state)
         S_IDLE: begin
            if (inta_fall) begin
               state_next  = S_ACK1;
               freeze_next = 1'b1;
               if (any_eligible) begin
                  isr_set           = ONE << winner;
                  clear_next        = ONE << winner;
                  vector_level_next = winner;
                  spurious_next     = 1'b0;
               end else begin
                  vector_level_next = 3'(NUM_IR - 1);
                  spurious_next     = 1'b1;
               end
            end
         end
         S_ACK1: begin
            if (inta_rise) state_next = S_WAIT2;
         end
         S_WAIT2: begin
            if (inta_fall) begin
               state_next     = S_ACK2;
               vector_en_next = 1'b1;
            end
         end
         S_ACK2: begin
            if (inta_rise) begin
               state_next     = S_IDLE;
               vector_en_next = 1'b0;
               freeze_next    = 1'b0;
               if (auto_eoi && !spurious) begin
                  aeoi_clr = ONE << vector_level;
                  aeoi_rot = rotate_on_aeoi;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase

      // EOI is accepted in every state and works on the current ISR.
      if (eoi_cmd) begin
         if (eoi_specific) begin
            eoi_target = eoi_level;
            eoi_hit    = in_service_reg[eoi_level];
         end else begin
            eoi_hit    = isr_found;
         end
      end
      if (eoi_hit) eoi_clr = ONE << eoi_target;

      // A set and a clear of the same bit in one cycle leaves the bit set.
      isr_next = (in_service_reg & ~eoi_clr & ~aeoi_clr) | isr_set;

      // Later assignments take precedence: EOI rotation beats AEOI rotation,
      // which beats an explicit set_priority.
      lowest_next = lowest_priority;
      if (set_priority)             lowest_next = set_level;
      if (aeoi_rot)                 lowest_next = vector_level;
      if (eoi_hit && eoi_rotate)    lowest_next = eoi_target;

      int_next = (state_next == S_IDLE) && any_eligible;
   end

   // State and output registers; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= S_IDLE;
         inta_q          <= 1'b1;
         spurious        <= 1'b0;
         int_out         <= 1'b0;
         clear_ir_line   <= '0;
         freeze          <= 1'b0;
         in_service_reg  <= '0;
         vector_level    <= 3'd0;
         vector_en       <= 1'b0;
         lowest_priority <= RESET_LOWEST;
      end else begin
         state           <= state_next;
         inta_q          <= inta_n;
         spurious        <= spurious_next;
         int_out         <= int_next;
         clear_ir_line   <= clear_next;
         freeze          <= freeze_next;
         in_service_reg  <= isr_next;
         vector_level    <= vector_level_next;
         vector_en       <= vector_en_next;
         lowest_priority <= lowest_next;
      end
   end

endmodule
